multdiv_sequencer: RTL and testbench
====================================

# multdiv_sequencer

Controller for the shared multi-cycle multiply/divide unit in the 5-stage pipeline. Accepts a mult/div issued from the DX stage, pulses the unit's start control, holds operands stable, and asserts `activeMultOrDiv` to the stall logic while the operation is in flight. On completion it arbitrates for the register-file write port against the normal MW writeback and writes either the result to `rd` or a status code to r30 on exception/timeout.

## Interface
- `TIMEOUT`, 40: BUSY cycles before the operation is forced to complete with an exception.
- `CW`, 6: cycle-counter width; must satisfy 2^CW > TIMEOUT.
- `STATUS_MULT`, 4: value written to r30 on mult exception.
- `STATUS_DIV`, 5: value written to r30 on div exception.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `multDX`  in  1  mult decoded in DX.
- `divDX`  in  1  div decoded in DX.
- `rdDX`  in  5  destination register of the DX instruction.
- `opA_DX`, `opB_DX`  in  32 each  bypassed operands in DX.
- `resultRDY`  in  1  unit result valid.
- `resultIn`  in  32  unit result.
- `exceptionIn`  in  1  unit exception (overflow, divide-by-zero); sampled with `resultRDY`.
- `weMW`  in  1  the pipeline's own writeback owns the write port this cycle.
- `ctrlMult`, `ctrlDiv`  out  1 each  one-cycle start pulses to the unit.
- `opA`, `opB`  out  32 each  latched operands to the unit.
- `activeMultOrDiv`  out  1  operation in flight; drives the stall logic.
- `wbValid`  out  1  write-port request/commit this cycle.
- `wbRd`  out  5  write address.
- `wbData`  out  32  write data.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, `multDX | divDX`:
  - latch `opA`/`opB`/`rdDX` and the op type (`multDX` wins if both are high);
  - register the matching start pulse;
  - clear the counter; go BUSY.
- BUSY:
  - The counter increments each cycle, saturating at TIMEOUT.
  - On `resultRDY`: latch `resultIn` and `exceptionIn`; go DONE.
  - Else, at count == TIMEOUT: latch exception = 1 and result = 0; go DONE.
- DONE:
  - Writeback target:
    - exception: `wbRd` = 30, `wbData` = STATUS_MULT/STATUS_DIV by op type;
    - else if rd ≠ 0: `wbRd` = rd, `wbData` = result;
    - else (rd == 0, no exception): no write; go IDLE next edge.
  - `wbValid` = `!weMW` (combinational).
  - When `wbValid` is high, the write commits that cycle; go IDLE.
  - Otherwise hold DONE with all outputs stable.
- `activeMultOrDiv` = (state ≠ IDLE), registered.
- `multDX`/`divDX` are ignored outside IDLE (DX is stalled by `activeMultOrDiv`).
- `opA`/`opB` change only on acceptance in IDLE.
- Reset values: state IDLE; counter, `opA`, `opB`, latched rd/result/exception = 0; all outputs 0.

## Timing
- Accept at edge E (IDLE, request high) → `ctrlMult`/`ctrlDiv` high during cycle E..E+1 only; `activeMultOrDiv` high from E.
- `resultRDY` is ignored in the cycle the start pulse is high.
- `resultRDY` at edge R → DONE from R; earliest `wbValid` in cycle R..R+1.
- Minimum latency from acceptance to write: 2 cycles + unit latency.
- Timeout: DONE entered at the edge where the counter reaches TIMEOUT (TIMEOUT BUSY cycles after acceptance).
- `weMW` high stalls the writeback indefinitely without losing data.
- Back-to-back: a new request in the IDLE cycle after DONE is accepted normally; no dead cycle is required.
- `reset` mid-operation: all outputs drop to 0 asynchronously; the in-flight result is discarded; the next request is accepted normally after `reset` falls.

## Test plan
- mult: `multDX`=1, `rdDX`=5, opA=7, opB=6; unit raises RDY with 42 four cycles after the pulse; `weMW`=0 → one `ctrlMult` pulse, `activeMultOrDiv` high throughout, then `wbValid`=1 with `wbRd`=5, `wbData`=42 for one cycle, then IDLE.
- div by zero: `divDX`=1, `rdDX`=3; RDY with `exceptionIn`=1 → `wbRd`=30, `wbData`=5; no write to r3.
- Timeout: `multDX`=1; `resultRDY` held low → DONE after 40 BUSY cycles; `wbRd`=30, `wbData`=4.
- Port conflict: result ready while `weMW`=1 for 3 cycles → `wbValid`=0 for 3 cycles, `activeMultOrDiv` stays 1, then a single write with the data unchanged.
- rd=0 and reset: mult with `rdDX`=0 completes with no `wbValid`. Separately, `reset` pulsed mid-BUSY → all outputs 0 immediately, and a following div with `rdDX`=2, 20/4 writes 5 to r2.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// Issue/complete sequencer for the shared multi-cycle mult/div unit.
// Owns the start pulse, operand hold, stall flag and result writeback.
module multdiv_sequencer #(
  parameter int          TIMEOUT     = 40,
  parameter int          CW          = 6,
  parameter logic [31:0] STATUS_MULT = 32'd4,
  parameter logic [31:0] STATUS_DIV  = 32'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        multDX,
  input  logic        divDX,
  input  logic [4:0]  rdDX,
  input  logic [31:0] opA_DX,
  input  logic [31:0] opB_DX,
  input  logic        resultRDY,
  input  logic [31:0] resultIn,
  input  logic        exceptionIn,
  input  logic        weMW,
  output logic        ctrlMult,
  output logic        ctrlDiv,
  output logic [31:0] opA,
  output logic [31:0] opB,
  output logic        activeMultOrDiv,
  output logic        wbValid,
  output logic [4:0]  wbRd,
  output logic [31:0] wbData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] LP_TMO    = CW'(TIMEOUT);
  localparam logic [4:0]    LP_STATRD = 5'd30;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_opA;
  logic [31:0]   r_opB;
  logic [4:0]    r_rd;
  logic [31:0]   r_result;
  logic          r_exc;
  logic          r_isMult;
  logic          r_ctrlMult;
  logic          r_ctrlDiv;
  logic          r_active;

  logic          w_accept;
  logic [CW-1:0] w_cnt_inc;
  logic          w_rdy;
  logic          w_timeout;
  logic          w_wr_needed;
  logic          w_wb_valid;

  always_comb begin
    w_accept    = (r_state == S_IDLE) && (multDX || divDX);
    w_cnt_inc   = (r_cnt == LP_TMO) ? r_cnt : r_cnt + 1'b1;
    // the unit cannot answer in the same cycle it is started
    w_rdy       = resultRDY && !(r_ctrlMult || r_ctrlDiv);
    w_timeout   = (w_cnt_inc == LP_TMO);
    w_wr_needed = r_exc || (r_rd != 5'd0);
    w_wb_valid  = (r_state == S_DONE) && w_wr_needed && !weMW;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (w_rdy || w_timeout) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!w_wr_needed || w_wb_valid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_opA      <= '0;
      r_opB      <= '0;
      r_rd       <= '0;
      r_result   <= '0;
      r_exc      <= 1'b0;
      r_isMult   <= 1'b0;
      r_ctrlMult <= 1'b0;
      r_ctrlDiv  <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_active   <= (w_state_nxt != S_IDLE);
      r_ctrlMult <= w_accept && multDX;
      r_ctrlDiv  <= w_accept && !multDX;
      if (w_accept) begin
        r_opA    <= opA_DX;
        r_opB    <= opB_DX;
        r_rd     <= rdDX;
        r_isMult <= multDX;
        r_cnt    <= '0;
        r_exc    <= 1'b0;
        r_result <= '0;
      end
      if (r_state == S_BUSY) begin
        r_cnt <= w_cnt_inc;
        if (w_rdy) begin
          r_result <= resultIn;
          r_exc    <= exceptionIn;
        end else if (w_timeout) begin
          r_result <= '0;
          r_exc    <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    wbRd   = 5'd0;
    wbData = 32'd0;
    if (r_state == S_DONE) begin
      if (r_exc) begin
        wbRd   = LP_STATRD;
        wbData = r_isMult ? STATUS_MULT : STATUS_DIV;
      end else begin
        wbRd   = r_rd;
        wbData = r_result;
      end
    end
  end

  assign wbValid         = w_wb_valid;
  assign ctrlMult        = r_ctrlMult;
  assign ctrlDiv         = r_ctrlDiv;
  assign opA             = r_opA;
  assign opB             = r_opB;
  assign activeMultOrDiv = r_active;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: mult, div-by-zero, timeout,
// port conflict, rd=0, back-to-back, async reset and RDY-during-pulse.
module tb_multdiv_sequencer;

  logic        clock;
  logic        reset;
  logic        multDX;
  logic        divDX;
  logic [4:0]  rdDX;
  logic [31:0] opA_DX;
  logic [31:0] opB_DX;
  logic        resultRDY;
  logic [31:0] resultIn;
  logic        exceptionIn;
  logic        weMW;
  logic        ctrlMult;
  logic        ctrlDiv;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        activeMultOrDiv;
  logic        wbValid;
  logic [4:0]  wbRd;
  logic [31:0] wbData;

  int checks;
  int errors;
  int wb_seen;

  multdiv_sequencer dut (
    .clock           (clock),
    .reset           (reset),
    .multDX          (multDX),
    .divDX           (divDX),
    .rdDX            (rdDX),
    .opA_DX          (opA_DX),
    .opB_DX          (opB_DX),
    .resultRDY       (resultRDY),
    .resultIn        (resultIn),
    .exceptionIn     (exceptionIn),
    .weMW            (weMW),
    .ctrlMult        (ctrlMult),
    .ctrlDiv         (ctrlDiv),
    .opA             (opA),
    .opB             (opB),
    .activeMultOrDiv (activeMultOrDiv),
    .wbValid         (wbValid),
    .wbRd            (wbRd),
    .wbData          (wbData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic m, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    multDX = m;
    divDX  = !m;
    rdDX   = rd;
    opA_DX = a;
    opB_DX = b;
    tick();
    multDX = 1'b0;
    divDX  = 1'b0;
    opA_DX = 32'hffff_ffff;
    opB_DX = 32'hffff_ffff;
  endtask

  task automatic finish_unit(input logic [31:0] res, input logic exc);
    resultRDY   = 1'b1;
    resultIn    = res;
    exceptionIn = exc;
    tick();
    resultRDY   = 1'b0;
    resultIn    = 32'hdead_beef;
    exceptionIn = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    multDX      = 1'b0;
    divDX       = 1'b0;
    rdDX        = 5'd0;
    opA_DX      = 32'd0;
    opB_DX      = 32'd0;
    resultRDY   = 1'b0;
    resultIn    = 32'd0;
    exceptionIn = 1'b0;
    weMW        = 1'b0;
    tick();
    tick();
    check("rst_active", 32'(activeMultOrDiv), 0);
    check("rst_wbv", 32'(wbValid), 0);
    check("rst_ctrl", {30'd0, ctrlMult, ctrlDiv}, 0);
    check("rst_opA", opA, 0);
    reset = 1'b0;
    tick();

    // mult 7*6 -> r5
    issue(1'b1, 5'd5, 32'd7, 32'd6);
    check("m_pulse", {30'd0, ctrlMult, ctrlDiv}, 32'd2);
    check("m_active", 32'(activeMultOrDiv), 1);
    check("m_opA", opA, 32'd7);
    check("m_opB", opB, 32'd6);
    tick();
    check("m_pulse_end", 32'(ctrlMult), 0);
    tick();
    tick();
    check("m_busy_wbv", 32'(wbValid), 0);
    check("m_busy_act", 32'(activeMultOrDiv), 1);
    finish_unit(32'd42, 1'b0);
    check("m_wbv", 32'(wbValid), 1);
    check("m_rd", 32'(wbRd), 32'd5);
    check("m_data", wbData, 32'd42);
    check("m_done_act", 32'(activeMultOrDiv), 1);
    tick();
    check("m_idle_wbv", 32'(wbValid), 0);
    check("m_idle_act", 32'(activeMultOrDiv), 0);

    // div by zero -> status in r30
    issue(1'b0, 5'd3, 32'd9, 32'd0);
    check("d_pulse", {30'd0, ctrlMult, ctrlDiv}, 32'd1);
    tick();
    finish_unit(32'd0, 1'b1);
    check("d_wbv", 32'(wbValid), 1);
    check("d_rd", 32'(wbRd), 32'd30);
    check("d_data", wbData, 32'd5);
    tick();
    check("d_idle_act", 32'(activeMultOrDiv), 0);

    // timeout: RDY never comes
    issue(1'b1, 5'd7, 32'd1, 32'd1);
    wb_seen = 0;
    for (int i = 0; i < 39; i++) begin
      if (wbValid || !activeMultOrDiv) wb_seen++;
      tick();
    end
    check("t_early", 32'(wb_seen), 0);
    check("t_wbv_39", 32'(wbValid), 0);
    tick();
    check("t_wbv", 32'(wbValid), 1);
    check("t_rd", 32'(wbRd), 32'd30);
    check("t_data", wbData, 32'd4);
    tick();
    check("t_idle_act", 32'(activeMultOrDiv), 0);

    // write-port conflict, then back-to-back rd=0 mult
    issue(1'b1, 5'd9, 32'd3, 32'd5);
    tick();
    weMW = 1'b1;
    finish_unit(32'd15, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("c_wbv_blk", 32'(wbValid), 0);
      check("c_act", 32'(activeMultOrDiv), 1);
      check("c_data_hold", wbData, 32'd15);
      if (i < 2) tick();
    end
    weMW = 1'b0;
    #1;
    check("c_wbv", 32'(wbValid), 1);
    check("c_rd", 32'(wbRd), 32'd9);
    check("c_data", wbData, 32'd15);
    tick();
    check("c_idle_act", 32'(activeMultOrDiv), 0);
    issue(1'b1, 5'd0, 32'd11, 32'd12);
    check("z_pulse", 32'(ctrlMult), 1);
    check("z_opA", opA, 32'd11);
    tick();
    finish_unit(32'd99, 1'b0);
    check("z_wbv", 32'(wbValid), 0);
    tick();
    check("z_idle_act", 32'(activeMultOrDiv), 0);
    check("z_idle_wbv", 32'(wbValid), 0);

    // async reset during the start pulse
    issue(1'b0, 5'd4, 32'd8, 32'd2);
    check("r_pre_pulse", 32'(ctrlDiv), 1);
    #2;
    reset = 1'b1;
    #1;
    check("r_ctrl", {30'd0, ctrlMult, ctrlDiv}, 0);
    check("r_act", 32'(activeMultOrDiv), 0);
    check("r_opA", opA, 0);
    check("r_wbv", 32'(wbValid), 0);
    tick();
    reset = 1'b0;
    tick();

    // 20/4 -> r2; RDY during the pulse cycle is ignored
    issue(1'b0, 5'd2, 32'd20, 32'd4);
    check("p_opA", opA, 32'd20);
    resultRDY = 1'b1;
    resultIn  = 32'd5;
    tick();
    check("p_ignored_wbv", 32'(wbValid), 0);
    check("p_ignored_act", 32'(activeMultOrDiv), 1);
    finish_unit(32'd5, 1'b0);
    check("p_wbv", 32'(wbValid), 1);
    check("p_rd", 32'(wbRd), 32'd2);
    check("p_data", wbData, 32'd5);
    tick();
    check("p_idle_act", 32'(activeMultOrDiv), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
